// File: rtl/locker_pkg.sv
// rtl/locker_pkg.sv - shared key codes, digit width and entry state encoding for the locker
package locker_pkg;

   localparam int DIGIT_W = 4;

   localparam logic [DIGIT_W-1:0] KEY_CLEAR = 4'hA;
   localparam logic [DIGIT_W-1:0] KEY_ENTER = 4'hB;
   localparam logic [DIGIT_W-1:0] KEY_BKSP  = 4'hC;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ENTRY,
      ST_FULL
   } state_t;

   function automatic logic is_digit(input logic [DIGIT_W-1:0] key);
      return key <= 4'd9;
   endfunction

endpackage

// File: rtl/entry_timer.sv
// rtl/entry_timer.sv - inactivity counter for code_entry; used only when CODE_TIMEOUT_EN is defined
module entry_timer #(
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic run,
   output logic expire
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] count;

   // A clear in the same cycle suppresses expiry so a late key always wins.
   assign expire = run && !clr && (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clr || !run || expire) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/code_entry.sv
// rtl/code_entry.sv - keypad digit collector presenting a packed code on ENTER
// Optional inactivity timeout enabled by defining CODE_TIMEOUT_EN.
module code_entry
   import locker_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int TIMEOUT_CYCLES = 50000000
) (
   input  logic                              clk,
   input  logic                              rst_n,
   input  logic                              key_valid,
   input  logic [DIGIT_W-1:0]                key_code,
   output logic [0:NUM_DIGITS*DIGIT_W-1]     code_out,
   output logic                              code_valid,
   output logic [2:0]                        digit_cnt,
   output logic                              entry_err,
   output logic                              timeout
);

   localparam int         CODE_W   = NUM_DIGITS * DIGIT_W;
   localparam logic [2:0] CNT_FULL = 3'(NUM_DIGITS);

   state_t              state, state_n;
   logic [0:CODE_W-1]   entry_buf, buf_n;
   logic [2:0]          cnt_n;
   logic [0:CODE_W-1]   code_n;
   logic                valid_n;
   logic                err_n;
   logic                tout_n;
   logic                expire;

`ifdef CODE_TIMEOUT_EN
   entry_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (key_valid),
      .run    (state != ST_IDLE),
      .expire (expire)
   );
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign expire = 1'b0;
`endif

   always_comb begin
      state_n = state;
      buf_n   = entry_buf;
      cnt_n   = digit_cnt;
      code_n  = code_out;
      valid_n = 1'b0;
      err_n   = 1'b0;
      tout_n  = 1'b0;

      if (key_valid) begin
         if (is_digit(key_code)) begin
            if (state == ST_FULL) begin
               err_n = 1'b1;
            end else begin
               // Slot 0 is the leftmost nibble, so digits fill in entry order.
               buf_n[int'(digit_cnt)*DIGIT_W +: DIGIT_W] = key_code;
               cnt_n   = digit_cnt + 3'd1;
               state_n = (cnt_n == CNT_FULL) ? ST_FULL : ST_ENTRY;
            end
         end else begin
            case (key_code)
               KEY_ENTER: begin
                  if (state == ST_FULL) begin
                     code_n  = entry_buf;
                     valid_n = 1'b1;
                  end else begin
                     err_n = 1'b1;
                  end
                  buf_n   = '0;
                  cnt_n   = 3'd0;
                  state_n = ST_IDLE;
               end
               KEY_CLEAR: begin
                  buf_n   = '0;
                  cnt_n   = 3'd0;
                  state_n = ST_IDLE;
               end
               KEY_BKSP: begin
                  if (state == ST_IDLE) begin
                     err_n = 1'b1;
                  end else begin
                     buf_n[(int'(digit_cnt) - 1)*DIGIT_W +: DIGIT_W] = '0;
                     cnt_n   = digit_cnt - 3'd1;
                     state_n = (cnt_n == 3'd0) ? ST_IDLE : ST_ENTRY;
                  end
               end
               default: begin
               end
            endcase
         end
      end else if (expire) begin
         buf_n   = '0;
         cnt_n   = 3'd0;
         state_n = ST_IDLE;
         tout_n  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         entry_buf  <= '0;
         digit_cnt  <= 3'd0;
         code_out   <= '0;
         code_valid <= 1'b0;
         entry_err  <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         state      <= state_n;
         entry_buf  <= buf_n;
         digit_cnt  <= cnt_n;
         code_out   <= code_n;
         code_valid <= valid_n;
         entry_err  <= err_n;
         timeout    <= tout_n;
      end
   end

endmodule

// File: tb/tb_code_entry.sv
// tb/tb_code_entry.sv - directed self-checking bench for code_entry with a submitted-code scoreboard
module tb_code_entry;

   logic        clk;
   logic        rst_n;
   logic        key_valid;
   logic [3:0]  key_code;
   logic [0:15] code_out;
   logic        code_valid;
   logic [2:0]  digit_cnt;
   logic        entry_err;
   logic        timeout;

   int checks   = 0;
   int failures = 0;
   logic [15:0] exp_q[$];

   localparam logic [3:0] K_CLR = 4'hA;
   localparam logic [3:0] K_ENT = 4'hB;
   localparam logic [3:0] K_BS  = 4'hC;

   code_entry #(
      .NUM_DIGITS     (4),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .code_out   (code_out),
      .code_valid (code_valid),
      .digit_cnt  (digit_cnt),
      .entry_err  (entry_err),
      .timeout    (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] k, input logic exp_valid, input logic exp_err,
                        input logic [2:0] exp_cnt);
      logic [15:0] want;
      @(negedge clk);
      key_valid = 1'b1;
      key_code  = k;
      @(posedge clk);
      #1;
      key_valid = 1'b0;
      check($sformatf("code_valid key=%h", k), 32'(code_valid), 32'(exp_valid));
      check($sformatf("entry_err key=%h", k), 32'(entry_err), 32'(exp_err));
      check($sformatf("digit_cnt key=%h", k), 32'(digit_cnt), 32'(exp_cnt));
      check($sformatf("timeout key=%h", k), 32'(timeout), 32'd0);
      if (code_valid === 1'b1) begin
         check("scoreboard_pending", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            check("code_out", 32'(code_out), 32'(want));
         end
      end
   endtask

   task automatic idle(input logic [2:0] exp_cnt, input logic exp_to);
      @(posedge clk);
      #1;
      check("idle code_valid", 32'(code_valid), 32'd0);
      check("idle entry_err", 32'(entry_err), 32'd0);
      check("idle timeout", 32'(timeout), 32'(exp_to));
      check("idle digit_cnt", 32'(digit_cnt), 32'(exp_cnt));
   endtask

   initial begin
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key_code  = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset code_out", 32'(code_out), 32'h0);
      check("reset digit_cnt", 32'(digit_cnt), 32'd0);
      check("reset code_valid", 32'(code_valid), 32'd0);
      check("reset entry_err", 32'(entry_err), 32'd0);
      check("reset timeout", 32'(timeout), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: full code submitted
      press(4'h1, 0, 0, 3'd1);
      press(4'h2, 0, 0, 3'd2);
      press(4'h3, 0, 0, 3'd3);
      press(4'h4, 0, 0, 3'd4);
      exp_q.push_back(16'h1234);
      press(K_ENT, 1, 0, 3'd0);
      idle(3'd0, 0);

      // 2: short entry rejected, previous code kept
      press(4'h5, 0, 0, 3'd1);
      press(4'h6, 0, 0, 3'd2);
      press(K_ENT, 0, 1, 3'd0);
      check("code_out held", 32'(code_out), 32'h1234);
      idle(3'd0, 0);

      // 3: fifth digit dropped
      press(4'h7, 0, 0, 3'd1);
      press(4'h8, 0, 0, 3'd2);
      press(4'h9, 0, 0, 3'd3);
      press(4'h0, 0, 0, 3'd4);
      press(4'h3, 0, 1, 3'd4);
      exp_q.push_back(16'h7890);
      press(K_ENT, 1, 0, 3'd0);

      // 4: backspace edit, then backspace on empty entry
      press(4'h4, 0, 0, 3'd1);
      press(4'h5, 0, 0, 3'd2);
      press(K_BS, 0, 0, 3'd1);
      press(4'h6, 0, 0, 3'd2);
      press(4'h7, 0, 0, 3'd3);
      press(4'h8, 0, 0, 3'd4);
      exp_q.push_back(16'h4678);
      press(K_ENT, 1, 0, 3'd0);
      press(K_BS, 0, 1, 3'd0);

      // 5: clear, ignored code, then a fresh code
      press(4'h1, 0, 0, 3'd1);
      press(4'h2, 0, 0, 3'd2);
      press(K_CLR, 0, 0, 3'd0);
      press(4'hD, 0, 0, 3'd0);
      press(4'h9, 0, 0, 3'd1);
      press(4'hF, 0, 0, 3'd1);
      press(4'h9, 0, 0, 3'd2);
      press(4'h9, 0, 0, 3'd3);
      press(4'h9, 0, 0, 3'd4);
      exp_q.push_back(16'h9999);
      press(K_ENT, 1, 0, 3'd0);
      check("code_out after submit", 32'(code_out), 32'h9999);

      // 6: asynchronous reset mid-entry
      press(4'h3, 0, 0, 3'd1);
      idle(3'd1, 0);
      idle(3'd1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check("async code_out", 32'(code_out), 32'h0);
      check("async digit_cnt", 32'(digit_cnt), 32'd0);
      check("async code_valid", 32'(code_valid), 32'd0);
      check("async entry_err", 32'(entry_err), 32'd0);
      repeat (2) begin
         @(posedge clk);
         #1;
         check("in reset code_valid", 32'(code_valid), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      idle(3'd0, 0);

`ifdef CODE_TIMEOUT_EN
      // Key arriving on the expiry cycle wins, then a full idle window times out.
      press(4'h3, 0, 0, 3'd1);
      repeat (7) idle(3'd1, 0);
      press(4'h4, 0, 0, 3'd2);
      repeat (7) idle(3'd2, 0);
      idle(3'd0, 1);
      idle(3'd0, 0);
`else
      press(4'h3, 0, 0, 3'd1);
      repeat (12) idle(3'd1, 0);
      press(K_CLR, 0, 0, 3'd0);
`endif

      check("scoreboard drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
